fir_filter_seq: RTL

FIR_FILTER_SEQ -- requirements
Module: fir_filter_seq

---
 rtl/fir_pkg.sv | 27 ++
 rtl/fir_round_sat.sv | 34 +++
 rtl/fir_filter_seq.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the sequential FIR filter.
//   state_e : controller state encoding (IDLE=0, MAC=1, OUT=2)
//   clog2   : ceiling log2 for elaboration-time width calculations
//   acc_w   : full-precision accumulator width for a DW x CW, TAPS-term sum
package fir_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMac  = 2'd1,
    StOut  = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned acc_w(input int unsigned dw, input int unsigned cw,
                                        input int unsigned taps);
    return dw + cw + clog2(taps);
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Arithmetic right shift (floor) followed by signed saturation.
//   acc_i : ACC_W-bit signed accumulator value
//   res_o : OUT_W-bit signed result, clipped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
module fir_round_sat #(
  parameter int unsigned ACC_W = 18,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned SHIFT = 0
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [OUT_W-1:0] res_o
);

  logic signed [ACC_W-1:0] shifted;
  assign shifted = acc_i >>> SHIFT;

  if (ACC_W > OUT_W) begin : g_sat
    // Value fits iff every bit from the output sign bit upward is identical.
    logic [ACC_W-OUT_W:0] top_bits;
    assign top_bits = shifted[ACC_W-1:OUT_W-1];

    always_comb begin
      if ((&top_bits) || (~|top_bits)) begin
        res_o = shifted[OUT_W-1:0];
      end else if (shifted[ACC_W-1]) begin
        res_o = {1'b1, {(OUT_W - 1){1'b0}}};
      end else begin
        res_o = {1'b0, {(OUT_W - 1){1'b1}}};
      end
    end
  end else begin : g_ext
    assign res_o = OUT_W'(shifted);
  end

endmodule

// File: rtl/fir_filter_seq.sv
// Sequential FIR filter: one shared DW x CW multiplier, one tap per cycle.
//   clk, rst (sync, active-high)
//   in_valid / in_ready / in_data       : sample input handshake
//   coef_we / coef_addr / coef_data     : coefficient write, honoured only in IDLE
//   out_valid / out_ready / out_data    : result output handshake
//   busy                                : high whenever the controller is not IDLE
// Timing: a sample accepted at edge E is multiplied through the taps at edges
// E+1..E+TAPS; the last accumulate also registers the result, so out_valid is
// high in the (TAPS+1)-th cycle after E and a streaming source sees one accept
// every TAPS+2 cycles.
module fir_filter_seq
  import fir_pkg::*;
#(
  parameter int unsigned TAPS  = 8,
  parameter int unsigned DW    = 8,
  parameter int unsigned CW    = 8,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned SHIFT = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DW-1:0]         in_data,
  input  logic                         coef_we,
  input  logic        [clog2(TAPS)-1:0] coef_addr,
  input  logic signed [CW-1:0]         coef_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [OUT_W-1:0]      out_data,
  output logic                         busy
);

  localparam int unsigned AW    = clog2(TAPS);
  localparam int unsigned ACC_W = acc_w(DW, CW, TAPS);
  localparam int unsigned PW    = DW + CW;

  state_e                  state_q, state_d;
  logic        [AW-1:0]    idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [OUT_W-1:0] out_q, out_d;
  logic signed [DW-1:0]    x_q [TAPS];
  logic signed [DW-1:0]    x_d [TAPS];
  logic signed [CW-1:0]    c_q [TAPS];
  logic signed [CW-1:0]    c_d [TAPS];

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [OUT_W-1:0] sat_res;

  // Single shared multiplier; both operands are signed so the product is exact.
  assign prod    = c_q[idx_q] * x_q[idx_q];
  assign acc_sum = acc_q + ACC_W'(prod);

  fir_round_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_round_sat (
    .acc_i (acc_sum),
    .res_o (sat_res)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    out_d   = out_q;
    x_d     = x_q;
    c_d     = c_q;

    unique case (state_q)
      StIdle: begin
        if (coef_we && (32'(coef_addr) < TAPS)) begin
          c_d[coef_addr] = coef_data;
        end
        if (in_valid) begin
          for (int unsigned i = 1; i < TAPS; i++) begin
            x_d[i] = x_q[i-1];
          end
          x_d[0]  = in_data;
          acc_d   = '0;
          idx_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = acc_sum;
        if (idx_q == AW'(TAPS - 1)) begin
          out_d   = sat_res;
          state_d = StOut;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      StOut: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      x_q     <= '{default: '0};
      c_q     <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      x_q     <= x_d;
      c_q     <= c_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StOut);
  assign busy      = (state_q != StIdle);
  assign out_data  = out_q;

endmodule
